// File: rtl/alu_seq_unit_if.sv
// Opcode constants and the command/result bus of the sequential ALU unit.

package alu_ops;
    localparam int unsigned OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] NOT_OP      = 4'd0;
    localparam logic [OPCODE_W-1:0] AND_OP      = 4'd1;
    localparam logic [OPCODE_W-1:0] OR_OP       = 4'd2;
    localparam logic [OPCODE_W-1:0] XOR_OP      = 4'd3;
    localparam logic [OPCODE_W-1:0] LL_SHIFT_OP = 4'd4;
    localparam logic [OPCODE_W-1:0] LR_SHIFT_OP = 4'd5;
    localparam logic [OPCODE_W-1:0] AL_SHIFT_OP = 4'd6;
    localparam logic [OPCODE_W-1:0] AR_SHIFT_OP = 4'd7;
endpackage

interface alu_seq_unit_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned OPCODE_W = alu_ops::OPCODE_W;

    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] opcode;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                cin;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    y;
    logic                cout;
    logic                overflow;
    logic                negative;
    logic                zero;
    logic                illegal;

    modport master (
        output in_valid, opcode, a, b, cin, out_ready,
        input  in_ready, out_valid, y, cout, overflow, negative, zero, illegal
    );

    modport slave (
        input  in_valid, opcode, a, b, cin, out_ready,
        output in_ready, out_valid, y, cout, overflow, negative, zero, illegal
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle logic ops, iterative 1-bit/cycle shifter,
// valid/ready on both command and result sides, no command overlap.

module alu_seq_unit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_unit_if.slave bus
);
    import alu_ops::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0]    work_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [OPCODE_W-1:0] op_q;
    logic                cin_q;
    logic [WIDTH-1:0]    y_q;
    logic                cout_q;
    logic                ovf_q;
    logic                neg_q;
    logic                zero_q;
    logic                ill_q;

    logic                accept_c;
    logic                is_logic_c;
    logic                is_shift_c;
    logic [CNT_W-1:0]    amount_c;
    logic [WIDTH-1:0]    logic_res_c;
    logic [WIDTH-1:0]    step_src_c;
    logic [OPCODE_W-1:0] step_op_c;
    logic [WIDTH-1:0]    step_val_c;
    logic                step_bit_c;
    logic                step_ovf_c;
    logic                load_y_c;
    logic [WIDTH-1:0]    y_load_c;

    // cin is captured for future carry-using ops; nothing consumes it yet
    logic unused_cin;
    assign unused_cin = cin_q;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign accept_c      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.y         = y_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.negative  = neg_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = ill_q;

    // Decode the incoming command and evaluate the single-cycle logic ops
    always_comb begin
        is_logic_c  = bus.opcode inside {NOT_OP, AND_OP, OR_OP, XOR_OP};
        is_shift_c  = bus.opcode inside {LL_SHIFT_OP, LR_SHIFT_OP, AL_SHIFT_OP, AR_SHIFT_OP};
        amount_c    = (32'(bus.b) >= WIDTH) ? CNT_W'(WIDTH) : CNT_W'(bus.b);
        logic_res_c = '0;
        case (bus.opcode)
            NOT_OP:  logic_res_c = ~bus.a;
            AND_OP:  logic_res_c = bus.a & bus.b;
            OR_OP:   logic_res_c = bus.a | bus.b;
            XOR_OP:  logic_res_c = bus.a ^ bus.b;
            default: logic_res_c = '0;
        endcase
    end

    // One shift step; the first step is taken on the accept edge from operand a
    always_comb begin
        step_src_c = (state_q == SHIFT) ? work_q : bus.a;
        step_op_c  = (state_q == SHIFT) ? op_q : bus.opcode;
        step_val_c = step_src_c;
        step_bit_c = 1'b0;
        step_ovf_c = 1'b0;
        case (step_op_c)
            LL_SHIFT_OP: begin
                step_val_c = {step_src_c[WIDTH-2:0], 1'b0};
                step_bit_c = step_src_c[WIDTH-1];
            end
            AL_SHIFT_OP: begin
                step_val_c = {step_src_c[WIDTH-2:0], 1'b0};
                step_bit_c = step_src_c[WIDTH-1];
                step_ovf_c = step_src_c[WIDTH-1] ^ step_src_c[WIDTH-2];
            end
            LR_SHIFT_OP: begin
                step_val_c = {1'b0, step_src_c[WIDTH-1:1]};
                step_bit_c = step_src_c[0];
            end
            AR_SHIFT_OP: begin
                step_val_c = {step_src_c[WIDTH-1], step_src_c[WIDTH-1:1]};
                step_bit_c = step_src_c[0];
            end
            default: begin
                step_val_c = step_src_c;
                step_bit_c = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and result-load strobe
    always_comb begin
        state_d  = state_q;
        load_y_c = 1'b0;
        y_load_c = '0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (is_logic_c) begin
                        state_d  = DONE;
                        load_y_c = 1'b1;
                        y_load_c = logic_res_c;
                    end else if (is_shift_c) begin
                        if (amount_c == '0) begin
                            state_d  = DONE;
                            load_y_c = 1'b1;
                            y_load_c = bus.a;
                        end else if (amount_c == CNT_W'(1)) begin
                            state_d  = DONE;
                            load_y_c = 1'b1;
                            y_load_c = step_val_c;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        state_d  = DONE;
                        load_y_c = 1'b1;
                        y_load_c = '0;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = DONE;
                    load_y_c = 1'b1;
                    y_load_c = step_val_c;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: command capture, shifter iteration, result and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
            cin_q  <= 1'b0;
            y_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            if (load_y_c) begin
                y_q    <= y_load_c;
                neg_q  <= y_load_c[WIDTH-1];
                zero_q <= (y_load_c == '0);
            end
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        op_q   <= bus.opcode;
                        cin_q  <= bus.cin;
                        ill_q  <= !(is_logic_c || is_shift_c);
                        work_q <= bus.a;
                        cnt_q  <= '0;
                        cout_q <= 1'b0;
                        ovf_q  <= 1'b0;
                        if (is_shift_c && (amount_c != '0)) begin
                            work_q <= step_val_c;
                            cout_q <= step_bit_c;
                            ovf_q  <= step_ovf_c;
                            cnt_q  <= amount_c - CNT_W'(1);
                        end
                    end
                end
                SHIFT: begin
                    work_q <= step_val_c;
                    cout_q <= step_bit_c;
                    ovf_q  <= ovf_q | step_ovf_c;
                    cnt_q  <= cnt_q - CNT_W'(1);
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: expected results are queued at issue
// time and compared against the DUT result, including measured latency.

module tb_alu_seq_unit;
    import alu_ops::*;

    localparam int unsigned WIDTH = 4;

    typedef struct packed {
        logic [3:0] y;
        logic       cout;
        logic       ovf;
        logic       neg;
        logic       zero;
        logic       ill;
        logic [7:0] lat;
    } res_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        logic       ill;
        logic [7:0] lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    alu_seq_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_seq_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference behaviour of one command
    function automatic res_t model(logic [3:0] op, logic [3:0] a, logic [3:0] b);
        res_t       r;
        int         n;
        logic [3:0] w;
        r     = '0;
        r.lat = 8'd1;
        case (op)
            NOT_OP: r.y = ~a;
            AND_OP: r.y = a & b;
            OR_OP:  r.y = a | b;
            XOR_OP: r.y = a ^ b;
            LL_SHIFT_OP, AL_SHIFT_OP, LR_SHIFT_OP, AR_SHIFT_OP: begin
                n = (b >= 4'd4) ? 4 : int'(b);
                w = a;
                for (int i = 0; i < n; i++) begin
                    if (op == LR_SHIFT_OP || op == AR_SHIFT_OP) begin
                        r.cout = w[0];
                        w = {(op == AR_SHIFT_OP) ? w[3] : 1'b0, w[3:1]};
                    end else begin
                        r.cout = w[3];
                        if (op == AL_SHIFT_OP && w[3] != w[2]) r.ovf = 1'b1;
                        w = {w[2:0], 1'b0};
                    end
                end
                r.y = w;
                if (n > 0) r.lat = 8'(n);
            end
            default: r.ill = 1'b1;
        endcase
        r.neg  = r.y[3];
        r.zero = (r.y == 4'd0);
        return r;
    endfunction

    // Wait for in_ready, present one command for one edge, queue its expectation
    task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: in_ready=%b required 1", bus.in_ready);
        end
        bus.opcode   = op;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = 1'($urandom);
        bus.in_valid = 1'b1;
        sb.push_back(model(op, a, b));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.opcode   = 4'($urandom);
        bus.a        = 4'($urandom);
        bus.b        = 4'($urandom);
    endtask

    // Count edges from the accept edge until out_valid shows (bounded)
    task automatic wait_result(output res_t obs, output bit ok);
        int lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        ok  = (bus.out_valid === 1'b1);
        obs = {bus.y, bus.cout, bus.overflow, bus.negative, bus.zero, bus.illegal, 8'(lat)};
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.opcode    = 4'd0;
        bus.a         = 4'd0;
        bus.b         = 4'd0;
        bus.cin       = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 0", bus.in_ready);
        end
        checks++;
        if ({bus.out_valid, bus.y, bus.cout, bus.overflow, bus.negative, bus.zero, bus.illegal} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0000000000",
                     {bus.out_valid, bus.y, bus.cout, bus.overflow, bus.negative, bus.zero, bus.illegal});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        bit seen = 1'b0;
        bus.opcode   = LL_SHIFT_OP;
        bus.a        = 4'b0001;
        bus.b        = 4'd3;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midshift_reset: out_valid=%b in_ready=%b required 0 0", bus.out_valid, bus.in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midshift_ready: got %b required 1", bus.in_ready);
        end
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || bus.y !== 4'd0) begin
            errors++;
            $display("FAIL midshift_discard: out_valid_seen=%b y=%b required 0 0000", seen, bus.y);
        end
    endtask

    task automatic test_logic();
        vec_t v[4];
        res_t obs;
        res_t exp;
        bit   ok;
        v = '{'{AND_OP, 4'b1010, 4'b0111, 4'b0010, 1'b0, 8'd1},
              '{XOR_OP, 4'b1100, 4'b0110, 4'b1010, 1'b0, 8'd1},
              '{OR_OP,  4'b1010, 4'b0101, 4'b1111, 1'b0, 8'd1},
              '{NOT_OP, 4'b0000, 4'b1111, 4'b1111, 1'b0, 8'd1}};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(v[i].op, v[i].a, v[i].b);
            wait_result(obs, ok);
            exp = sb.pop_front();
            checks++;
            if (!ok || obs !== exp) begin
                errors++;
                $display("FAIL logic_%0d: got %h expected %h", i, obs, exp);
            end
            checks++;
            if ({obs.y, obs.ill, obs.lat} !== {v[i].y, v[i].ill, v[i].lat}) begin
                errors++;
                $display("FAIL logic_plan_%0d: y/ill/lat got %b/%b/%0d required %b/%b/%0d",
                         i, obs.y, obs.ill, obs.lat, v[i].y, v[i].ill, v[i].lat);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL logic_retire_%0d: out_valid=%b in_ready=%b required 0 1", i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_shift();
        vec_t v[8];
        res_t obs;
        res_t exp;
        bit   ok;
        v = '{'{LL_SHIFT_OP, 4'b0001, 4'd3, 4'b1000, 1'b0, 8'd3},
              '{AL_SHIFT_OP, 4'b1000, 4'd1, 4'b0000, 1'b0, 8'd1},
              '{AR_SHIFT_OP, 4'b1001, 4'd1, 4'b1100, 1'b0, 8'd1},
              '{AR_SHIFT_OP, 4'b1110, 4'd7, 4'b1111, 1'b0, 8'd4},
              '{LR_SHIFT_OP, 4'b1011, 4'd0, 4'b1011, 1'b0, 8'd1},
              '{LL_SHIFT_OP, 4'b1011, 4'd4, 4'b0000, 1'b0, 8'd4},
              '{LR_SHIFT_OP, 4'b1000, 4'd9, 4'b0000, 1'b0, 8'd4},
              '{AL_SHIFT_OP, 4'b0011, 4'd2, 4'b1100, 1'b0, 8'd2}};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(v[i].op, v[i].a, v[i].b);
            wait_result(obs, ok);
            exp = sb.pop_front();
            checks++;
            if (!ok || obs !== exp) begin
                errors++;
                $display("FAIL shift_%0d: got %h expected %h", i, obs, exp);
            end
            checks++;
            if ({obs.y, obs.ill, obs.lat} !== {v[i].y, v[i].ill, v[i].lat}) begin
                errors++;
                $display("FAIL shift_plan_%0d: y/ill/lat got %b/%b/%0d required %b/%b/%0d",
                         i, obs.y, obs.ill, obs.lat, v[i].y, v[i].ill, v[i].lat);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        res_t obs;
        res_t exp;
        bit   ok;
        bus.out_ready = 1'b0;
        issue(XOR_OP, 4'b1100, 4'b1010);
        wait_result(obs, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || obs !== exp || obs.y !== 4'b0110) begin
            errors++;
            $display("FAIL bp_result: got %h expected %h", obs, exp);
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.opcode   = NOT_OP;
            bus.a        = 4'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.y, bus.illegal} !== {1'b1, 1'b0, 4'b0110, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid/ready/y got %b/%b/%b required 1/0/0110",
                         i, bus.out_valid, bus.in_ready, bus.y);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.y !== 4'b0110) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b y=%b required 0 1 0110",
                     bus.out_valid, bus.in_ready, bus.y);
        end
    endtask

    task automatic test_illegal();
        vec_t v[3];
        res_t obs;
        res_t exp;
        bit   ok;
        v = '{'{4'hF,   4'b1111, 4'b0000, 4'b0000, 1'b1, 8'd1},
              '{NOT_OP, 4'b0101, 4'b0000, 4'b1010, 1'b0, 8'd1},
              '{4'h9,   4'b0110, 4'b0011, 4'b0000, 1'b1, 8'd1}};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(v[i].op, v[i].a, v[i].b);
            wait_result(obs, ok);
            exp = sb.pop_front();
            checks++;
            if (!ok || obs !== exp) begin
                errors++;
                $display("FAIL illegal_%0d: got %h expected %h", i, obs, exp);
            end
            checks++;
            if ({obs.y, obs.ill, obs.lat} !== {v[i].y, v[i].ill, v[i].lat}) begin
                errors++;
                $display("FAIL illegal_plan_%0d: y/ill/lat got %b/%b/%0d required %b/%b/%0d",
                         i, obs.y, obs.ill, obs.lat, v[i].y, v[i].ill, v[i].lat);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        res_t       obs;
        res_t       exp;
        bit         ok;
        logic [3:0] op;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 9));
            if (op > 4'd7) op = 4'hC;
            issue(op, 4'($urandom), 4'($urandom));
            wait_result(obs, ok);
            exp = sb.pop_front();
            checks++;
            if (!ok || obs !== exp) begin
                errors++;
                $display("FAIL b2b_%0d op=%0d: got %h expected %h", i, op, obs, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reset_mid_shift();
        test_logic();
        test_shift();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
